vec_mem_seq: RTL and testbench

- MEM-stage sequencer between the EX/MEM pipeline register and the 24-bit-wide data memory.
- Splits each vector load/store (LANES x LANE_W bits) into one memory beat per lane, and handles a scalar load/store as a single beat.
- Holds the front of the pipeline with stall until the access completes.
- Presents assembled load results to the MEM/WB register.

---
 rtl/vec_mem_pkg.sv | 15 +
 rtl/vec_mem_seq_if.sv | 30 +++
 rtl/vec_mem_seq.sv | 104 ++++++++++
 tb/tb_vec_mem_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_pkg.sv
// Shared types and constants for the MEM-stage vector/scalar memory sequencer.
package vec_mem_pkg;
  localparam int LANES_DFLT  = 8;
  localparam int LANE_W_DFLT = 24;
  localparam int ADDR_W_DFLT = 21;
  localparam int VEC_W       = LANES_DFLT * LANE_W_DFLT;

  // mem_op bit positions from the EX/MEM mem field
  localparam int MEMOP_VLD = 0;
  localparam int MEMOP_VST = 1;
  localparam int MEMOP_SLD = 2;
  localparam int MEMOP_SST = 3;

  typedef enum logic [2:0] {IDLE, VLOAD, VSTORE, SCALAR, DONE} state_t;
endpackage

// File: rtl/vec_mem_seq_if.sv
// Pipeline-side and memory-side signals of the MEM-stage sequencer.
interface vec_mem_seq_if #(
  parameter int LANES  = 8,
  parameter int LANE_W = 24,
  parameter int ADDR_W = 21
);
  logic [3:0]                   mem_op;
  logic [ADDR_W-1:0]            base_addr;
  logic [LANES-1:0][LANE_W-1:0] store_vec;
  logic [ADDR_W-1:0]            store_scl;
  logic [LANE_W-1:0]            mem_rdata;
  logic                         mem_ready;
  logic [ADDR_W-1:0]            mem_addr;
  logic [LANE_W-1:0]            mem_wdata;
  logic                         mem_re;
  logic                         mem_we;
  logic [LANES-1:0][LANE_W-1:0] load_vec;
  logic [ADDR_W-1:0]            load_scl;
  logic                         stall;
  logic                         done;

  modport master (
    output mem_op, base_addr, store_vec, store_scl, mem_rdata, mem_ready,
    input  mem_addr, mem_wdata, mem_re, mem_we, load_vec, load_scl, stall, done
  );
  modport slave (
    input  mem_op, base_addr, store_vec, store_scl, mem_rdata, mem_ready,
    output mem_addr, mem_wdata, mem_re, mem_we, load_vec, load_scl, stall, done
  );
endinterface

// File: rtl/vec_mem_seq.sv
// MEM-stage sequencer: one memory beat per lane for vector ops, one beat for
// scalar ops; stalls the front of the pipe until the access completes.
module vec_mem_seq
  import vec_mem_pkg::*;
#(
  parameter int LANES  = LANES_DFLT,
  parameter int LANE_W = LANE_W_DFLT,
  parameter int ADDR_W = ADDR_W_DFLT
) (
  input  logic          clk,
  input  logic          rst,
  vec_mem_seq_if.slave  bus
);
  localparam int LW = $clog2(LANES);

  state_t                       state, state_n;
  logic [LW-1:0]                lane;
  logic                         is_load, is_vec;
  logic [ADDR_W-1:0]            base_q, scl_q;
  logic [LANES-1:0][LANE_W-1:0] vec_q, ld_vec_q;
  logic [ADDR_W-1:0]            ld_scl_q;
  logic                         busy_op;

  assign busy_op = (bus.mem_op != 4'b0);

  always_comb begin
    state_n       = state;
    bus.stall     = 1'b0;
    bus.done      = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: begin
        // gated by rst so every output reads 0 while reset is held
        bus.stall = busy_op && rst;
        if (busy_op) begin
          if (bus.mem_op[MEMOP_VST])      state_n = VSTORE;
          else if (bus.mem_op[MEMOP_VLD]) state_n = VLOAD;
          else                            state_n = SCALAR;
        end
      end
      VLOAD, VSTORE: begin
        bus.stall     = 1'b1;
        bus.mem_re    = (state == VLOAD);
        bus.mem_we    = (state == VSTORE);
        bus.mem_addr  = base_q + ADDR_W'(lane);
        bus.mem_wdata = (state == VSTORE) ? vec_q[lane] : '0;
        if (bus.mem_ready && lane == LW'(LANES-1)) state_n = DONE;
      end
      SCALAR: begin
        bus.stall     = 1'b1;
        bus.mem_re    = is_load;
        bus.mem_we    = !is_load;
        bus.mem_addr  = base_q;
        bus.mem_wdata = is_load ? '0 : LANE_W'(scl_q);
        if (bus.mem_ready) state_n = DONE;
      end
      DONE: begin
        // mem_op here is the op just served; never re-issue it
        bus.done = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lane     <= '0;
      is_load  <= 1'b0;
      is_vec   <= 1'b0;
      base_q   <= '0;
      scl_q    <= '0;
      vec_q    <= '0;
      ld_vec_q <= '0;
      ld_scl_q <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (busy_op) begin
          base_q  <= bus.base_addr;
          vec_q   <= bus.store_vec;
          scl_q   <= bus.store_scl;
          lane    <= '0;
          is_vec  <= bus.mem_op[MEMOP_VST] | bus.mem_op[MEMOP_VLD];
          is_load <= !bus.mem_op[MEMOP_VST] &&
                     (bus.mem_op[MEMOP_VLD] || !bus.mem_op[MEMOP_SST]);
        end
        VLOAD, VSTORE: if (bus.mem_ready && is_vec) begin
          if (is_load) ld_vec_q[lane] <= bus.mem_rdata;
          lane <= lane + 1'b1;
        end
        SCALAR: if (bus.mem_ready && is_load) ld_scl_q <= bus.mem_rdata[ADDR_W-1:0];
        default: ;
      endcase
    end
  end

  assign bus.load_vec = ld_vec_q;
  assign bus.load_scl = ld_scl_q;
endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq: the bench acts as pipeline and data memory.
module tb_vec_mem_seq;
  localparam int LANES = 8, LANE_W = 24, ADDR_W = 21;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vec_mem_seq_if #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) bus();
  vec_mem_seq #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk = 0, n_pass = 0;
  logic [ADDR_W-1:0] wa[$], ra[$];
  logic [LANE_W-1:0] wd[$];
  int stall_n, done_n, cycles, hold_seen, held, hold_n, extra_act;
  bit fin;
  logic [ADDR_W-1:0] cur_base, hold_addr;
  logic [LANE_W-1:0] rd_base;
  bit rd_const;
  logic [LANES-1:0][LANE_W-1:0] exp_vec;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Drives one op, plays memory on each posedge, stops after done (+2 idle
  // cycles) or right after the beat of abort_lane completes (asserts rst).
  task automatic run_op(input logic [3:0] op, input logic [ADDR_W-1:0] base, input int abort_lane);
    wa.delete(); wd.delete(); ra.delete();
    stall_n = 0; done_n = 0; cycles = 0; hold_seen = 0; held = 0; extra_act = 0; fin = 0;
    cur_base = base;
    bus.mem_op = op;
    bus.base_addr = base;
    for (int c = 0; c < 60 && !fin; c++) begin
      @(posedge clk);
      if (bus.stall) stall_n++;
      if (bus.done) begin done_n++; fin = 1; cycles = c + 1; end
      if ((bus.mem_re || bus.mem_we) && hold_n > 0 && bus.mem_addr == hold_addr) hold_seen++;
      bus.mem_rdata = rd_const ? rd_base : rd_base + LANE_W'(ADDR_W'(bus.mem_addr - cur_base));
      bus.mem_ready = 1'b1;
      if ((bus.mem_re || bus.mem_we) && hold_n > 0 && bus.mem_addr == hold_addr && held < hold_n) begin
        bus.mem_ready = 1'b0;
        held++;
      end
      if (bus.mem_ready && bus.mem_we) begin wa.push_back(bus.mem_addr); wd.push_back(bus.mem_wdata); end
      if (bus.mem_ready && bus.mem_re) ra.push_back(bus.mem_addr);
      if (abort_lane >= 0 && bus.mem_we && bus.mem_ready &&
          int'(ADDR_W'(bus.mem_addr - cur_base)) == abort_lane) begin
        @(negedge clk); #1;
        rst = 1'b0;
        return;
      end
      @(negedge clk); #1;
    end
    bus.mem_op = 4'b0;
    chk("no_timeout", 192'(fin), 192'd1);
    repeat (2) begin
      @(posedge clk);
      if (bus.stall || bus.done || bus.mem_re || bus.mem_we) extra_act++;
      @(negedge clk); #1;
    end
  endtask

  function automatic logic [191:0] q_a(input int k, input bit rd);
    if (rd) return (k < ra.size()) ? 192'(ra[k]) : '1;
    return (k < wa.size()) ? 192'(wa[k]) : '1;
  endfunction

  initial begin
    bus.mem_op = '0; bus.base_addr = '0; bus.store_vec = '0; bus.store_scl = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;
    hold_n = 0; hold_addr = '0; rd_const = 0; rd_base = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 192'(bus.stall), 0);
    chk("rst_done", 192'(bus.done), 0);
    chk("rst_re_we", 192'({bus.mem_re, bus.mem_we}), 0);
    chk("rst_addr", 192'(bus.mem_addr), 0);
    chk("rst_load_vec", bus.load_vec, 0);
    chk("rst_load_scl", 192'(bus.load_scl), 0);
    rst = 1'b1;
    bus.mem_ready = 1'b1;

    // vector store
    for (int k = 0; k < LANES; k++) bus.store_vec[k] = 24'h0A0000 + LANE_W'(k);
    run_op(4'b0010, 21'h000100, -1);
    chk("vst_nw", wa.size(), 8);
    for (int k = 0; k < LANES; k++) begin
      chk($sformatf("vst_addr%0d", k), q_a(k, 0), 192'(21'h100 + k));
      chk($sformatf("vst_data%0d", k), (k < wd.size()) ? 192'(wd[k]) : '1, 192'(24'h0A0000 + k));
    end
    chk("vst_nr", ra.size(), 0);
    chk("vst_stall", stall_n, 9);
    chk("vst_done", done_n, 1);
    chk("vst_cycles", cycles, 10);
    chk("vst_quiet", extra_act, 0);
    chk("vst_load_vec", bus.load_vec, 0);

    // vector load, 2 wait states on lane 3
    rd_base = 24'h110000; hold_addr = 21'h000203; hold_n = 2;
    run_op(4'b0001, 21'h000200, -1);
    hold_n = 0;
    for (int k = 0; k < LANES; k++) exp_vec[k] = 24'h110000 + LANE_W'(k);
    chk("vld_load_vec", bus.load_vec, exp_vec);
    chk("vld_cycles", cycles, 12);
    chk("vld_hold203", hold_seen, 3);
    chk("vld_stall", stall_n, 11);
    chk("vld_nr", ra.size(), 8);
    chk("vld_nw", wa.size(), 0);

    // address wrap
    rd_base = 24'h220000;
    run_op(4'b0001, 21'h1FFFFE, -1);
    for (int k = 0; k < LANES; k++) begin
      chk($sformatf("wrap_addr%0d", k), q_a(k, 1), 192'(ADDR_W'(21'h1FFFFE + k)));
      exp_vec[k] = 24'h220000 + LANE_W'(k);
    end
    chk("wrap_load_vec", bus.load_vec, exp_vec);
    chk("wrap_cycles", cycles, 10);

    // scalar store
    bus.store_scl = 21'h1ABCDE;
    run_op(4'b1000, 21'h000040, -1);
    chk("sst_nw", wa.size(), 1);
    chk("sst_addr", q_a(0, 0), 192'(21'h40));
    chk("sst_data", (wd.size() > 0) ? 192'(wd[0]) : '1, 192'(24'h1ABCDE));
    chk("sst_nr", ra.size(), 0);
    chk("sst_cycles", cycles, 3);
    chk("sst_stall", stall_n, 2);
    chk("sst_load_scl", 192'(bus.load_scl), 0);

    // scalar load truncates to ADDR_W
    rd_const = 1; rd_base = 24'hFFFFFF;
    run_op(4'b0100, 21'h000041, -1);
    rd_const = 0;
    chk("sld_load_scl", 192'(bus.load_scl), 192'(21'h1FFFFF));
    chk("sld_cycles", cycles, 3);
    chk("sld_stall", stall_n, 2);
    chk("sld_addr", q_a(0, 1), 192'(21'h41));
    chk("sld_nw", wa.size(), 0);
    chk("sld_load_vec", bus.load_vec, exp_vec);

    // priority: all bits set -> vector store only
    for (int k = 0; k < LANES; k++) bus.store_vec[k] = 24'h330000 + LANE_W'(k);
    run_op(4'b1111, 21'h000010, -1);
    chk("pri_nw", wa.size(), 8);
    chk("pri_addr0", q_a(0, 0), 192'(21'h10));
    chk("pri_addr7", q_a(7, 0), 192'(21'h17));
    chk("pri_data7", (wd.size() > 7) ? 192'(wd[7]) : '1, 192'(24'h330007));
    chk("pri_nr", ra.size(), 0);
    chk("pri_load_scl", 192'(bus.load_scl), 192'(21'h1FFFFF));
    chk("pri_load_vec", bus.load_vec, exp_vec);

    // reset after lane 4 of a vector store
    for (int k = 0; k < LANES; k++) bus.store_vec[k] = 24'h440000 + LANE_W'(k);
    run_op(4'b0010, 21'h000300, 4);
    #1;
    chk("rmb_nw", wa.size(), 5);
    chk("rmb_we", 192'(bus.mem_we), 0);
    chk("rmb_re", 192'(bus.mem_re), 0);
    chk("rmb_stall", 192'(bus.stall), 0);
    chk("rmb_done", 192'(bus.done), 0);
    chk("rmb_load_vec", bus.load_vec, 0);
    bus.mem_op = 4'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    extra_act = 0;
    repeat (6) begin
      @(posedge clk);
      if (bus.stall || bus.done || bus.mem_re || bus.mem_we) extra_act++;
      @(negedge clk); #1;
    end
    chk("rmb_quiet", extra_act, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
